// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad digit-entry block: key bit positions,
// key codes and the debounce FSM state type.
package keypad_pkg;

   localparam int unsigned KB_0   = 3;
   localparam int unsigned KB_1   = 7;
   localparam int unsigned KB_2   = 6;
   localparam int unsigned KB_3   = 5;
   localparam int unsigned KB_4   = 11;
   localparam int unsigned KB_5   = 10;
   localparam int unsigned KB_6   = 9;
   localparam int unsigned KB_7   = 15;
   localparam int unsigned KB_8   = 14;
   localparam int unsigned KB_9   = 13;
   localparam int unsigned KB_CLR = 12;
   localparam int unsigned KB_BS  = 8;
   localparam int unsigned KB_ENT = 4;

   localparam logic [3:0] KC_0   = 4'h0;
   localparam logic [3:0] KC_1   = 4'h1;
   localparam logic [3:0] KC_2   = 4'h2;
   localparam logic [3:0] KC_3   = 4'h3;
   localparam logic [3:0] KC_4   = 4'h4;
   localparam logic [3:0] KC_5   = 4'h5;
   localparam logic [3:0] KC_6   = 4'h6;
   localparam logic [3:0] KC_7   = 4'h7;
   localparam logic [3:0] KC_8   = 4'h8;
   localparam logic [3:0] KC_9   = 4'h9;
   localparam logic [3:0] KC_BS  = 4'hB;
   localparam logic [3:0] KC_CLR = 4'hC;
   localparam logic [3:0] KC_ENT = 4'hE;

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_HELD         = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } kp_state_e;

endpackage

// File: rtl/keypad_onehot_decode.sv
// Combinational keypad decoder: exactly one legal key bit gives valid=1;
// idle, multi-bit and unused-bit patterns all give valid=0.
module keypad_onehot_decode
   import keypad_pkg::*;
(
   input  logic [15:0] onehot,
   output logic        valid,
   output logic        is_digit,
   output logic [3:0]  code
);

   always_comb begin
      valid    = 1'b1;
      is_digit = 1'b1;
      code     = KC_0;
      case (onehot)
         16'h1 << KB_0:   code = KC_0;
         16'h1 << KB_1:   code = KC_1;
         16'h1 << KB_2:   code = KC_2;
         16'h1 << KB_3:   code = KC_3;
         16'h1 << KB_4:   code = KC_4;
         16'h1 << KB_5:   code = KC_5;
         16'h1 << KB_6:   code = KC_6;
         16'h1 << KB_7:   code = KC_7;
         16'h1 << KB_8:   code = KC_8;
         16'h1 << KB_9:   code = KC_9;
         16'h1 << KB_CLR: begin code = KC_CLR; is_digit = 1'b0; end
         16'h1 << KB_BS:  begin code = KC_BS;  is_digit = 1'b0; end
         16'h1 << KB_ENT: begin code = KC_ENT; is_digit = 1'b0; end
         default: begin
            valid    = 1'b0;
            is_digit = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/keypad_digit_entry.sv
// Debounced keypad front end feeding a BCD entry buffer with Backspace,
// Clear and Enter; one action per physical press.
module keypad_digit_entry
   import keypad_pkg::*;
#(
   parameter int NUM_DIGITS    = 3,
   parameter int STABLE_CYCLES = 4,
   parameter int SHIFT_MODE    = 0
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [15:0]                       onehot,
   output logic [4*NUM_DIGITS-1:0]           digits,
   output logic [$clog2(NUM_DIGITS+1)-1:0]   count,
   output logic                              full,
   output logic                              key_valid,
   output logic [3:0]                        key_code,
   output logic [4*NUM_DIGITS-1:0]           value,
   output logic                              value_valid,
   output logic                              overflow,
   output kp_state_e                         state_dbg
);

   localparam int DW   = 4 * NUM_DIGITS;
   localparam int CNTW = $clog2(NUM_DIGITS + 1);
   localparam int SCW  = $clog2(STABLE_CYCLES + 1);
   localparam logic [SCW-1:0]  STABLE_N = SCW'(STABLE_CYCLES);
   localparam logic [SCW-1:0]  S_ONE    = SCW'(1);
   localparam logic [CNTW-1:0] FULL_N   = CNTW'(NUM_DIGITS);
   localparam logic [CNTW-1:0] C_ONE    = CNTW'(1);

   logic       dec_valid;
   logic       dec_is_digit;
   logic [3:0] dec_code;

   keypad_onehot_decode u_decode (
      .onehot   (onehot),
      .valid    (dec_valid),
      .is_digit (dec_is_digit),
      .code     (dec_code)
   );

   kp_state_e       state_q, state_d;
   logic [SCW-1:0]  stab_q, stab_d;
   logic [3:0]      pend_q, pend_d;
   logic [DW-1:0]   digits_q, digits_d;
   logic [CNTW-1:0] count_q, count_d;
   logic            key_valid_q, key_valid_d;
   logic [3:0]      key_code_q, key_code_d;
   logic [DW-1:0]   value_q, value_d;
   logic            value_valid_q, value_valid_d;
   logic            overflow_q, overflow_d;
   logic            accept;
   logic [DW-1:0]   shifted;

   // key_valid, value_valid and overflow are single-cycle strobes with no
   // back-pressure: a consumer must sample them on the cycle they are high.
   always_comb begin
      state_d       = state_q;
      stab_d        = stab_q;
      pend_d        = pend_q;
      digits_d      = digits_q;
      count_d       = count_q;
      key_valid_d   = 1'b0;
      key_code_d    = key_code_q;
      value_d       = value_q;
      value_valid_d = 1'b0;
      overflow_d    = 1'b0;
      accept        = 1'b0;
      shifted       = digits_q << 4;
      shifted[3:0]  = dec_code;

      case (state_q)
         ST_IDLE: begin
            if (dec_valid) begin
               pend_d = dec_code;
               stab_d = S_ONE;
               if (STABLE_N == S_ONE) begin
                  accept  = 1'b1;
                  state_d = ST_HELD;
               end else begin
                  state_d = ST_PRESS_WAIT;
               end
            end
         end
         ST_PRESS_WAIT: begin
            if (!dec_valid) begin
               state_d = ST_IDLE;
               stab_d  = '0;
            end else if (dec_code != pend_q) begin
               pend_d = dec_code;
               stab_d = S_ONE;
            end else begin
               stab_d = stab_q + S_ONE;
               if (stab_q + S_ONE == STABLE_N) begin
                  accept  = 1'b1;
                  state_d = ST_HELD;
               end
            end
         end
         ST_HELD: begin
            if (onehot == 16'h0) begin
               if (STABLE_N == S_ONE) begin
                  state_d = ST_IDLE;
                  stab_d  = '0;
               end else begin
                  state_d = ST_RELEASE_WAIT;
                  stab_d  = S_ONE;
               end
            end
         end
         ST_RELEASE_WAIT: begin
            if (onehot != 16'h0) begin
               state_d = ST_HELD;
            end else if (stab_q + S_ONE == STABLE_N) begin
               state_d = ST_IDLE;
               stab_d  = '0;
            end else begin
               stab_d = stab_q + S_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            stab_d  = '0;
         end
      endcase

      // accept is only raised while dec_* describes the key being taken.
      if (accept) begin
         key_valid_d = 1'b1;
         key_code_d  = dec_code;
         if (dec_is_digit) begin
            if (count_q == FULL_N) begin
               overflow_d = 1'b1;
            end else begin
               if (SHIFT_MODE == 0) digits_d[4*int'(count_q) +: 4] = dec_code;
               else                 digits_d = shifted;
               count_d = count_q + C_ONE;
            end
         end else if (dec_code == KC_BS) begin
            if (count_q != '0) begin
               if (SHIFT_MODE == 0) digits_d[4*(int'(count_q)-1) +: 4] = 4'h0;
               else                 digits_d = digits_q >> 4;
               count_d = count_q - C_ONE;
            end
         end else if (dec_code == KC_CLR) begin
            digits_d = '0;
            count_d  = '0;
         end else if (dec_code == KC_ENT) begin
            if (count_q != '0) begin
               value_d       = digits_q;
               value_valid_d = 1'b1;
               digits_d      = '0;
               count_d       = '0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         stab_q        <= '0;
         pend_q        <= '0;
         digits_q      <= '0;
         count_q       <= '0;
         key_valid_q   <= 1'b0;
         key_code_q    <= '0;
         value_q       <= '0;
         value_valid_q <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         stab_q        <= stab_d;
         pend_q        <= pend_d;
         digits_q      <= digits_d;
         count_q       <= count_d;
         key_valid_q   <= key_valid_d;
         key_code_q    <= key_code_d;
         value_q       <= value_d;
         value_valid_q <= value_valid_d;
         overflow_q    <= overflow_d;
      end
   end

   assign digits      = digits_q;
   assign count       = count_q;
   assign full        = (count_q == FULL_N);
   assign key_valid   = key_valid_q;
   assign key_code    = key_code_q;
   assign value       = value_q;
   assign value_valid = value_valid_q;
   assign overflow    = overflow_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Bench for keypad_digit_entry: one slot-fill and one shift-mode instance
// driven by the same keypad stimulus, with key and value scoreboards.
module tb_keypad_digit_entry;
   import keypad_pkg::*;

   localparam int ND = 3;
   localparam int SC = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] onehot = 16'h0;

   logic [11:0] d0_digits, d1_digits, d0_value, d1_value;
   logic [1:0]  d0_count, d1_count;
   logic        d0_full, d1_full, d0_kv, d1_kv, d0_vv, d1_vv, d0_ov, d1_ov;
   logic [3:0]  d0_code, d1_code;
   kp_state_e   d0_state, d1_state;

   int n_pass  = 0;
   int n_total = 0;
   int kv0_cnt = 0, kv1_cnt = 0, ov0_cnt = 0, ov1_cnt = 0, vv0_cnt = 0, vv1_cnt = 0;

   logic [7:0]  exp0_q[$];
   logic [7:0]  exp1_q[$];
   logic [11:0] val0_q[$];
   logic [11:0] val1_q[$];

   always #5 clk = ~clk;

   keypad_digit_entry #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC), .SHIFT_MODE(0)) dut0 (
      .clk(clk), .rst(rst), .onehot(onehot), .digits(d0_digits), .count(d0_count),
      .full(d0_full), .key_valid(d0_kv), .key_code(d0_code), .value(d0_value),
      .value_valid(d0_vv), .overflow(d0_ov), .state_dbg(d0_state)
   );

   keypad_digit_entry #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC), .SHIFT_MODE(1)) dut1 (
      .clk(clk), .rst(rst), .onehot(onehot), .digits(d1_digits), .count(d1_count),
      .full(d1_full), .key_valid(d1_kv), .key_code(d1_code), .value(d1_value),
      .value_valid(d1_vv), .overflow(d1_ov), .state_dbg(d1_state)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic int bit_of(input logic [3:0] code);
      case (code)
         4'h0: return 3;   4'h1: return 7;   4'h2: return 6;   4'h3: return 5;
         4'h4: return 11;  4'h5: return 10;  4'h6: return 9;   4'h7: return 15;
         4'h8: return 14;  4'h9: return 13;  4'hC: return 12;  4'hB: return 8;
         default: return 4;
      endcase
   endfunction

   // Scoreboard monitors: every pulse pops its expectation, 8'hFF means none.
   always @(negedge clk) begin
      if (!rst) begin
         if (d0_kv) begin
            kv0_cnt++;
            chk("dut0_key_code", {28'h0, d0_code}, {24'h0, (exp0_q.size() > 0) ? exp0_q.pop_front() : 8'hFF});
         end
         if (d1_kv) begin
            kv1_cnt++;
            chk("dut1_key_code", {28'h0, d1_code}, {24'h0, (exp1_q.size() > 0) ? exp1_q.pop_front() : 8'hFF});
         end
         if (d0_vv) begin
            vv0_cnt++;
            chk("dut0_value", {20'h0, d0_value}, (val0_q.size() > 0) ? {20'h0, val0_q.pop_front()} : 32'hFFFF_FFFF);
         end
         if (d1_vv) begin
            vv1_cnt++;
            chk("dut1_value", {20'h0, d1_value}, (val1_q.size() > 0) ? {20'h0, val1_q.pop_front()} : 32'hFFFF_FFFF);
         end
         if (d0_ov) ov0_cnt++;
         if (d1_ov) ov1_cnt++;
      end
   end

   task automatic idle(input int n);
      onehot = 16'h0;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_key(input logic [3:0] code);
      exp0_q.push_back({4'h0, code});
      exp1_q.push_back({4'h0, code});
      onehot = 16'h1 << bit_of(code);
      repeat (SC + 3) @(negedge clk);
      idle(SC + 3);
   endtask

   task automatic chk_buf(input string tag, input logic [11:0] e0, input logic [11:0] e1,
                          input logic [1:0] c0, input logic [1:0] c1);
      chk({tag, "_d0_digits"}, {20'h0, d0_digits}, {20'h0, e0});
      chk({tag, "_d1_digits"}, {20'h0, d1_digits}, {20'h0, e1});
      chk({tag, "_d0_count"},  {30'h0, d0_count},  {30'h0, c0});
      chk({tag, "_d1_count"},  {30'h0, d1_count},  {30'h0, c1});
   endtask

   task automatic chk_all_zero(input string tag);
      chk_buf(tag, 12'h0, 12'h0, 2'd0, 2'd0);
      chk({tag, "_outs0"}, {20'h0, d0_value, d0_full, d0_kv, d0_vv, d0_ov, d0_code}, 32'h0);
      chk({tag, "_outs1"}, {20'h0, d1_value, d1_full, d1_kv, d1_vv, d1_ov, d1_code}, 32'h0);
      chk({tag, "_state"}, {30'h0, d0_state}, {30'h0, ST_IDLE});
   endtask

   initial begin
      int kv_before;
      #3;
      chk_all_zero("reset_noclk");
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;

      // Single press held long: exactly one acceptance after SC samples.
      exp0_q.push_back(8'h1);
      exp1_q.push_back(8'h1);
      onehot = 16'h1 << 7;
      repeat (SC - 1) @(negedge clk);
      chk("latency_early_kv", {31'h0, d0_kv}, 32'h0);
      @(negedge clk);
      chk("latency_kv", {31'h0, d0_kv}, 32'h1);
      chk_buf("first", 12'h001, 12'h001, 2'd1, 2'd1);
      repeat (20) @(negedge clk);
      chk("held_one_pulse", kv0_cnt, 1);
      idle(SC + 3);

      do_key(4'h2);
      do_key(4'h3);
      chk_buf("three", 12'h321, 12'h123, 2'd3, 2'd3);
      chk("full0", {31'h0, d0_full}, 32'h1);
      chk("full1", {31'h0, d1_full}, 32'h1);
      do_key(4'h5);
      chk_buf("overflow", 12'h321, 12'h123, 2'd3, 2'd3);
      chk("ov0_cnt", ov0_cnt, 1);
      chk("ov1_cnt", ov1_cnt, 1);

      do_key(4'hC);
      chk_buf("clear", 12'h0, 12'h0, 2'd0, 2'd0);

      do_key(4'h1);
      do_key(4'h2);
      do_key(4'h3);
      do_key(4'hB);
      chk_buf("backspace", 12'h021, 12'h012, 2'd2, 2'd2);
      val0_q.push_back(12'h021);
      val1_q.push_back(12'h012);
      do_key(4'hE);
      chk_buf("enter", 12'h0, 12'h0, 2'd0, 2'd0);
      chk("vv0_cnt", vv0_cnt, 1);
      chk("vv1_cnt", vv1_cnt, 1);
      do_key(4'hE);
      do_key(4'hB);
      chk("empty_enter_vv", vv1_cnt, 1);
      chk_buf("empty_bs", 12'h0, 12'h0, 2'd0, 2'd0);

      // Bounce and illegal patterns must never be accepted.
      kv_before = kv0_cnt;
      onehot = 16'h1 << 6; repeat (3) @(negedge clk);
      idle(1);
      onehot = 16'h1 << 6; repeat (3) @(negedge clk);
      idle(SC + 2);
      onehot = (16'h1 << 6) | (16'h1 << 5); repeat (10) @(negedge clk);
      idle(SC + 2);
      onehot = 16'h1 << $urandom_range(0, 2); repeat (10) @(negedge clk);
      idle(SC + 2);
      chk("bounce_no_accept", kv0_cnt, kv_before);
      chk_buf("bounce", 12'h0, 12'h0, 2'd0, 2'd0);

      // Release glitch: one key_valid for the whole sequence.
      kv_before = kv0_cnt;
      exp0_q.push_back(8'h2);
      exp1_q.push_back(8'h2);
      onehot = 16'h1 << 6; repeat (SC + 2) @(negedge clk);
      idle(2);
      onehot = 16'h1 << 6; @(negedge clk);
      idle(SC + 4);
      chk("glitch_one_pulse", kv0_cnt, kv_before + 1);
      chk_buf("glitch", 12'h002, 12'h002, 2'd1, 2'd1);

      // Asynchronous reset in PRESS_WAIT, key held through release.
      onehot = 16'h1 << 7;
      repeat (2) @(negedge clk);
      chk("pw_state", {30'h0, d0_state}, {30'h0, ST_PRESS_WAIT});
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk_all_zero("async_rst");
      @(negedge clk);
      exp0_q.push_back(8'h1);
      exp1_q.push_back(8'h1);
      rst = 1'b0;
      repeat (SC - 1) @(negedge clk);
      chk("rst_early_kv", {31'h0, d0_kv}, 32'h0);
      @(negedge clk);
      chk("rst_accept_kv", {31'h0, d1_kv}, 32'h1);
      chk_buf("after_rst", 12'h001, 12'h001, 2'd1, 2'd1);
      idle(SC + 4);

      chk("exp0_drained", exp0_q.size(), 0);
      chk("exp1_drained", exp1_q.size(), 0);
      chk("val_drained", val0_q.size() + val1_q.size(), 0);
      chk("ov0_total", ov0_cnt, 1);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
